seq_multiplier: RTL and testbench

//  - Multi-cycle shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH product, one partial sum per clock.
//  - Sits downstream of the 32-bit `adder` block, consuming its Y and C outputs as the partial-sum datapath.
//  - Start/done handshake with the ALU control; result held stable until the next accepted start.

---
 rtl/mul_pkg.sv | 6 +
 rtl/adder.sv | 14 +
 rtl/seq_multiplier.sv | 123 ++++++++++++
 tb/tb_seq_multiplier.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and sizing for the sequential shift-and-add multiplier.
package mul_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
  localparam int MUL_WIDTH = 32;
  localparam int CNT_W = $clog2(MUL_WIDTH);
endpackage

// File: rtl/adder.sv
// Ripple-free behavioural adder: y/c = a + b + cin, v = signed overflow.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] y,
  output logic             c,
  output logic             v
);
  assign {c, y} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign v = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/seq_multiplier.sv
// Shift-and-add WIDTH x WIDTH multiplier, one partial sum per clock via the shared adder.
// Optional two's-complement operands when SIGNED_MULT_EN is defined.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  mul_state_t         state_reg, state_next;
  logic [WIDTH-1:0]   mcand_reg, hi_reg, lo_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] product_reg;

  logic [WIDTH-1:0]   add_b, add_y;
  logic               add_c, add_v;
  logic [WIDTH-1:0]   hi_shift, lo_shift;
  logic [WIDTH-1:0]   load_mcand, load_lo;
  logic [2*WIDTH-1:0] product_final;
  logic               accept;
  logic               unused_v;

  assign add_b = lo_reg[0] ? mcand_reg : '0;

  adder #(.WIDTH(WIDTH)) u_adder (
    .a   (hi_reg),
    .b   (add_b),
    .cin (1'b0),
    .y   (add_y),
    .c   (add_c),
    .v   (add_v)
  );

  assign unused_v = add_v;

  // {c, y, lo} >> 1: carry lands in the top bit, adder LSB shifts into lo.
  assign hi_shift = {add_c, add_y[WIDTH-1:1]};
  assign lo_shift = {add_y[0], lo_reg[WIDTH-1:1]};

`ifdef SIGNED_MULT_EN
  logic neg_reg;

  assign load_mcand    = (is_signed && a[WIDTH-1]) ? -a : a;
  assign load_lo       = (is_signed && b[WIDTH-1]) ? -b : b;
  assign product_final = neg_reg ? -{hi_shift, lo_shift} : {hi_shift, lo_shift};

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_reg <= 1'b0;
    end else if (accept) begin
      neg_reg <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
    end
  end
`else
  logic unused_signed;

  assign unused_signed = is_signed;
  assign load_mcand    = a;
  assign load_lo       = b;
  assign product_final = {hi_shift, lo_shift};
`endif

  assign accept = start && ready;

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_reg == '0) state_next = DONE;
      end
      DONE: begin
        ready      = 1'b1;
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      mcand_reg   <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        mcand_reg <= load_mcand;
        hi_reg    <= '0;
        lo_reg    <= load_lo;
        cnt_reg   <= CNT_W'(WIDTH - 1);
      end else if (state_reg == RUN) begin
        hi_reg  <= hi_shift;
        lo_reg  <= lo_shift;
        cnt_reg <= cnt_reg - 1'b1;
        // The last shift and the result capture happen on the same edge.
        if (cnt_reg == '0) product_reg <= product_final;
      end
    end
  end

  assign product = product_reg;
endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: transaction-level model checked every cycle plus directed literal checks.
module tb_seq_multiplier;
`ifdef SIGNED_MULT_EN
  localparam bit SIGNED_ON = 1'b1;
  localparam logic [63:0] EXP_S1 = 64'hFFFF_FFFF_FFFF_FFF1;
  localparam logic [63:0] EXP_S2 = 64'h0000_0000_8000_0000;
`else
  localparam bit SIGNED_ON = 1'b0;
  localparam logic [63:0] EXP_S1 = 64'h0000_0004_FFFF_FFF1;
  localparam logic [63:0] EXP_S2 = 64'h7FFF_FFFF_8000_0000;
`endif

  logic        clk = 1'b0;
  logic        reset, start, is_signed;
  logic [31:0] a, b;
  logic        ready, busy, done;
  logic [63:0] product;

  int checks = 0;
  int errors = 0;

  seq_multiplier dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic signed [63:0] sx, sy;
    logic [63:0] r;
    r = {32'b0, x} * {32'b0, y};
    if (s && SIGNED_ON) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      r  = sx * sy;
    end
    return r;
  endfunction

  // Model: an accepted start yields a done pulse 33 cycles later carrying the exact product.
  int          m_left = 0;
  logic [63:0] m_result = '0;
  logic [63:0] m_product = '0;
  logic        m_done = 1'b0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_left    = 0;
      m_done    = 1'b0;
      m_product = '0;
      chk_en    = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_product = m_result;
          m_done    = 1'b1;
        end
      end else if (start) begin
        m_result = ref_mul(a, b, is_signed);
        m_left   = 32;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", {63'b0, ready}, {63'b0, m_left == 0});
      check("busy", {63'b0, busy}, {63'b0, m_left > 0});
      check("done", {63'b0, done}, {63'b0, m_done});
      check("product", product, m_product);
    end
  end

  task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic s);
    a = x; b = y; is_signed = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) break;
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y,
                        input logic s, input logic [63:0] exp);
    int n;
    launch(x, y, s);
    wait_done(n);
    $display("op %s: a=%h b=%h signed=%0d product=%h cycles=%0d", name, x, y, s, product, n);
    check({name, "_latency"}, 64'(n), 64'd33);
    check({name, "_product"}, product, exp);
    check({name, "_model"}, m_product, exp);
  endtask

  initial begin
    int n, done_cnt, prod_changes;
    logic [63:0] held;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    @(posedge clk);
    @(negedge clk);
    check("rst_ready", {63'b0, ready}, 64'd1);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_product", product, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    run_op("u3x5", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F);
    run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    run_op("s_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, EXP_S1);
    run_op("s_min", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, EXP_S2);

    // start held through RUN with changing operands
    a = 32'd7; b = 32'd9; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      a = $urandom; b = $urandom;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_done(n);
    $display("op hold: product=%h cycles=%0d", product, n);
    check("hold_latency", 64'(n), 64'd13);
    check("hold_product", product, 64'd63);

    // back-to-back: start in the DONE cycle
    launch(32'd3, 32'd5, 1'b0);
    wait_done(n);
    check("b2b_first", product, 64'd15);
    a = 32'd10; b = 32'd11; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n);
    $display("op b2b: product=%h cycles=%0d", product, n);
    check("b2b_latency", 64'(n), 64'd33);
    check("b2b_product", product, 64'd110);

    // reset in the middle of RUN
    launch(32'd1234, 32'd5678, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_ready", {63'b0, ready}, 64'd1);
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_product", product, 64'd0);
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    $display("op abort: done pulses after reset=%0d", done_cnt);
    check("abort_no_done", 64'(done_cnt), 64'd0);

    // idle stability after a result
    run_op("idle", 32'd100, 32'd200, 1'b0, 64'd20000);
    held = product;
    done_cnt = 0;
    prod_changes = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (product !== held) prod_changes++;
    end
    $display("op idle: done pulses=%0d product changes=%0d", done_cnt, prod_changes);
    check("idle_done", 64'(done_cnt), 64'd0);
    check("idle_product", 64'(prod_changes), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
